stack_ctrl: RTL
===============

# stack_ctrl

Command front end for the team's circular stack. It accepts PUSH/POP/REPLACE/DEPTH commands on a valid/ready channel and drives the stack's push, pop and data inputs. It tracks occupancy so the stack never wraps, and returns one response per command on a valid/ready channel, carrying popped data or an error flag. It sits directly upstream of the stack, and both blocks share i_clk and i_rst.

## Interface
- WIDTH, 18: word width; must match the stack's word width; must be ≥ DEPTH_LOG2+1.
- DEPTH_LOG2, 4: the stack holds 2**DEPTH_LOG2 words.

- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command ready.
- i_cmd_op  in  2  command: 00 DEPTH, 01 PUSH, 10 POP, 11 REPLACE.
- i_cmd_data  in  WIDTH  data for PUSH and REPLACE.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response ready.
- o_rsp_data  out  WIDTH  response data.
- o_rsp_err  out  1  response error: command rejected.
- o_stk_push  out  1  to stack push input.
- o_stk_pop  out  1  to stack pop input.
- o_stk_data  out  WIDTH  to stack data input.
- i_stk_data  in  WIDTH  from stack data output (registered there, valid the cycle after a pop strobe).
- o_depth  out  DEPTH_LOG2+1  committed occupancy, 0..2**DEPTH_LOG2.
- o_full  out  1  o_depth == 2**DEPTH_LOG2.
- o_empty  out  1  o_depth == 0.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **Readiness:** o_cmd_ready = 1 only in IDLE. A command is accepted on a cycle with i_cmd_valid && o_cmd_ready. i_cmd_op and i_cmd_data are sampled only at acceptance.
- **PUSH, not full:**
  - IDLE→ISSUE. o_stk_push=1 and o_stk_data=i_cmd_data, registered.
  - Depth +1 at the acceptance edge.
  - ISSUE→RESP with data = pushed word, err=0.
- **POP, not empty:**
  - IDLE→ISSUE with o_stk_pop=1. Depth −1 at the acceptance edge.
  - ISSUE→WAIT.
  - In WAIT, capture i_stk_data into o_rsp_data at end of cycle. WAIT→RESP with err=0.
- **REPLACE, not empty:**
  - IDLE→ISSUE with o_stk_push=1, o_stk_pop=1 and o_stk_data=i_cmd_data. Depth unchanged.
  - ISSUE→WAIT→RESP. Data = old top of stack, captured in WAIT.
- **Rejected commands:** PUSH when full, or POP/REPLACE when empty.
  - IDLE→RESP directly, with err=1 and data=0.
  - No strobe is issued and depth is unchanged.
- **DEPTH:** IDLE→RESP with data = o_depth zero-extended, err=0. No strobe.
- **RESP:**
  - o_rsp_valid=1.
  - o_rsp_data and o_rsp_err are held stable until i_rsp_ready.
  - On handshake, RESP→IDLE.
- **Strobes:** o_stk_push and o_stk_pop are high only in ISSUE, for exactly one cycle per command. o_stk_data holds its last value otherwise.
- **No wrap:** because of the guards, the stack never wraps. Depth saturates logically at 0 and 2**DEPTH_LOG2, and it is never an arithmetic wrap.
- **Reset:** every register clears.
  - State IDLE, depth 0.
  - o_stk_push, o_stk_pop, o_rsp_valid and o_rsp_err are 0.
  - o_stk_data and o_rsp_data are 0.
  - Hence o_cmd_ready=1, o_empty=1, o_full=0 in the first cycle after reset.
- **Reset mid-operation:** the command in flight is abandoned and no response is produced. The stack is reset on the same edge, so depth 0 stays consistent with it.

## Timing
- Acceptance at cycle N.
- PUSH: strobe in N+1, o_rsp_valid from N+2.
- POP/REPLACE: strobe in N+1, stack output valid in N+2, o_rsp_valid from N+3.
- DEPTH and rejected commands: o_rsp_valid from N+1.
- Response handshake at cycle M → o_cmd_ready=1 in M+1. Minimum command spacing: PUSH 3 cycles, POP 4 cycles, DEPTH 2 cycles.
- o_depth, o_full and o_empty update at the acceptance edge, i.e. they are visible in N+1.

## Test plan
1. **Reset, then DEPTH:** rsp data 0x00000, err=0 at N+1; o_empty=1, o_full=0, o_cmd_ready=1.
2. **Push and pop order:**
   - Stimulus: PUSH 0x00011, 0x00022, 0x00033, then POP ×3.
   - Required: responses 0x00033, 0x00022, 0x00011 at N+3 each; o_depth steps 1,2,3,2,1,0.
   - Required: exactly one o_stk_pop pulse per POP.
3. **POP on empty:** err=1, data 0 at N+1; no o_stk_pop pulse; o_depth stays 0.
4. **Full guard (DEPTH_LOG2=4):**
   - Stimulus: 16 PUSHes of 0x00001..0x00010, then a 17th PUSH, then POP.
   - Required: o_full=1 after the 16 PUSHes.
   - Required: the 17th PUSH returns err=1 with no o_stk_push pulse.
   - Required: the following POP returns 0x00010 and o_full=0.
5. **REPLACE:**
   - Stimulus: PUSH 0x0AAAA, then REPLACE 0x05555, then POP.
   - Required: REPLACE returns 0x0AAAA, with push and pop strobes high together for one cycle; depth stays 1.
   - Required: the POP returns 0x05555 and depth goes to 0.
6. **Backpressure and reset during RESP:**
   - Stimulus: hold i_rsp_ready=0 for 5 cycles during a POP response.
   - Required: o_rsp_valid, data and err stay stable; o_cmd_ready stays 0.
   - Stimulus: assert i_rst while in RESP.
   - Required: the next cycle shows o_rsp_valid=0, o_depth=0, o_cmd_ready=1.

Source files
------------

// File: rtl/stack_ctrl.sv
// Command front end for the circular stack: turns PUSH/POP/REPLACE/DEPTH commands
// into stack strobes, tracks occupancy so the stack never wraps, and returns one response per command.
module stack_ctrl #(
    parameter int WIDTH      = 18,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [WIDTH-1:0]      i_cmd_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [WIDTH-1:0]      o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_stk_push,
    output logic                  o_stk_pop,
    output logic [WIDTH-1:0]      o_stk_data,
    input  logic [WIDTH-1:0]      i_stk_data,
    output logic [DEPTH_LOG2:0]   o_depth,
    output logic                  o_full,
    output logic                  o_empty
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {
        OP_DEPTH   = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_t;

    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE        = {{DEPTH_LOG2{1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [DEPTH_LOG2:0] depth, depth_nxt;
    logic                push_q, push_nxt;
    logic                pop_q, pop_nxt;
    logic [WIDTH-1:0]    stk_data_q, stk_data_nxt;
    logic [WIDTH-1:0]    rsp_data_q, rsp_data_nxt;
    logic                rsp_err_q, rsp_err_nxt;
    logic                need_wait, need_wait_nxt;
    logic                full, empty;
    op_t                 cmd_op;

    assign cmd_op = op_t'(i_cmd_op);
    assign full   = (depth == FULL_LEVEL);
    assign empty  = (depth == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            depth      <= '0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            stk_data_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            need_wait  <= 1'b0;
        end else begin
            state      <= state_nxt;
            depth      <= depth_nxt;
            push_q     <= push_nxt;
            pop_q      <= pop_nxt;
            stk_data_q <= stk_data_nxt;
            rsp_data_q <= rsp_data_nxt;
            rsp_err_q  <= rsp_err_nxt;
            need_wait  <= need_wait_nxt;
        end
    end

    // Occupancy is committed at acceptance so the guards always see the depth
    // the stack will have once the pending strobe lands.
    always_comb begin
        state_nxt     = state;
        depth_nxt     = depth;
        push_nxt      = 1'b0;
        pop_nxt       = 1'b0;
        stk_data_nxt  = stk_data_q;
        rsp_data_nxt  = rsp_data_q;
        rsp_err_nxt   = rsp_err_q;
        need_wait_nxt = need_wait;

        unique case (state)
            IDLE: begin
                if (i_cmd_valid) begin
                    unique case (cmd_op)
                        OP_DEPTH: begin
                            rsp_data_nxt = WIDTH'(depth);
                            rsp_err_nxt  = 1'b0;
                            state_nxt    = RESP;
                        end
                        OP_PUSH: begin
                            if (full) begin
                                rsp_data_nxt = '0;
                                rsp_err_nxt  = 1'b1;
                                state_nxt    = RESP;
                            end else begin
                                push_nxt      = 1'b1;
                                stk_data_nxt  = i_cmd_data;
                                rsp_data_nxt  = i_cmd_data;
                                rsp_err_nxt   = 1'b0;
                                depth_nxt     = depth + ONE;
                                need_wait_nxt = 1'b0;
                                state_nxt     = ISSUE;
                            end
                        end
                        OP_POP, OP_REPLACE: begin
                            if (empty) begin
                                rsp_data_nxt = '0;
                                rsp_err_nxt  = 1'b1;
                                state_nxt    = RESP;
                            end else begin
                                pop_nxt       = 1'b1;
                                need_wait_nxt = 1'b1;
                                state_nxt     = ISSUE;
                                if (cmd_op == OP_REPLACE) begin
                                    push_nxt     = 1'b1;
                                    stk_data_nxt = i_cmd_data;
                                end else begin
                                    depth_nxt = depth - ONE;
                                end
                            end
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            ISSUE: state_nxt = need_wait ? WAIT : RESP;
            WAIT: begin
                rsp_data_nxt = i_stk_data;
                rsp_err_nxt  = 1'b0;
                state_nxt    = RESP;
            end
            RESP: begin
                if (i_rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_cmd_ready = (state == IDLE);
    assign o_rsp_valid = (state == RESP);
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_stk_push  = push_q;
    assign o_stk_pop   = pop_q;
    assign o_stk_data  = stk_data_q;
    assign o_depth     = depth;
    assign o_full      = full;
    assign o_empty     = empty;

endmodule
